// File: rtl/bcd2bin32.sv
// bcd2bin32: sequential 10-digit BCD to 32-bit binary converter.
// One digit per clock, MSD first, acc = acc*10 + digit with shift-add only.
module bcd2bin32 #(
    parameter bit SAT = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    input  logic [3:0]  bcd0,
    input  logic [3:0]  bcd1,
    input  logic [3:0]  bcd2,
    input  logic [3:0]  bcd3,
    input  logic [3:0]  bcd4,
    input  logic [3:0]  bcd5,
    input  logic [3:0]  bcd6,
    input  logic [3:0]  bcd7,
    input  logic [3:0]  bcd8,
    input  logic [3:0]  bcd9,
    output logic [31:0] bin,
    output logic        busy,
    output logic        fin,
    output logic        ovf,
    output logic        err
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      r_state;
    logic [39:0] r_sh;
    logic [33:0] r_acc;
    logic [3:0]  r_cnt;
    logic        r_err_int;

    logic [39:0] w_digits;
    logic        w_bad;
    logic [33:0] w_next;
    logic        w_ovf;

    assign w_digits = {bcd9, bcd8, bcd7, bcd6, bcd5,
                       bcd4, bcd3, bcd2, bcd1, bcd0};

    assign w_bad = (bcd0 > 4'd9) | (bcd1 > 4'd9) | (bcd2 > 4'd9) |
                   (bcd3 > 4'd9) | (bcd4 > 4'd9) | (bcd5 > 4'd9) |
                   (bcd6 > 4'd9) | (bcd7 > 4'd9) | (bcd8 > 4'd9) |
                   (bcd9 > 4'd9);

    // 34 bits hold the worst case even with all-0xF digits, so no wrap here
    assign w_next = (r_acc << 3) + (r_acc << 1) + {30'd0, r_sh[39:36]};
    assign w_ovf  = |w_next[33:32];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_sh      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err_int <= 1'b0;
            bin       <= '0;
            busy      <= 1'b0;
            fin       <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            fin <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_sh      <= w_digits;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_err_int <= w_bad;
                        busy      <= 1'b1;
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    r_acc <= w_next;
                    r_sh  <= {r_sh[35:0], 4'h0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        ovf     <= w_ovf;
                        bin     <= (SAT && w_ovf) ? 32'hFFFF_FFFF
                                                  : w_next[31:0];
                        err     <= r_err_int;
                        fin     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin32.sv
// tb_bcd2bin32: directed and random checks of bcd2bin32 against a
// positional-arithmetic model; SAT=0 and SAT=1 instances share stimulus.
module tb_bcd2bin32;

    logic        CLK;
    logic        RST;
    logic        en;
    logic [39:0] dv;
    logic [31:0] bin0, bin1;
    logic        busy0, busy1, fin0, fin1, ovf0, ovf1, err0, err1;

    int n_chk;
    int n_fail;

    longint unsigned prev0, prev1;

    bcd2bin32 #(.SAT(1'b0)) u_dut0 (
        .CLK(CLK), .RST(RST), .en(en),
        .bcd0(dv[3:0]),   .bcd1(dv[7:4]),   .bcd2(dv[11:8]),
        .bcd3(dv[15:12]), .bcd4(dv[19:16]), .bcd5(dv[23:20]),
        .bcd6(dv[27:24]), .bcd7(dv[31:28]), .bcd8(dv[35:32]),
        .bcd9(dv[39:36]),
        .bin(bin0), .busy(busy0), .fin(fin0), .ovf(ovf0), .err(err0)
    );

    bcd2bin32 #(.SAT(1'b1)) u_dut1 (
        .CLK(CLK), .RST(RST), .en(en),
        .bcd0(dv[3:0]),   .bcd1(dv[7:4]),   .bcd2(dv[11:8]),
        .bcd3(dv[15:12]), .bcd4(dv[19:16]), .bcd5(dv[23:20]),
        .bcd6(dv[27:24]), .bcd7(dv[31:28]), .bcd8(dv[35:32]),
        .bcd9(dv[39:36]),
        .bin(bin1), .busy(busy1), .fin(fin1), .ovf(ovf1), .err(err1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input longint unsigned obs,
                         input longint unsigned exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] dec(input longint unsigned n);
        logic [39:0] r;
        longint unsigned t;
        t = n;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // value = sum of digit * 10^position, raw digit values even if > 9
    function automatic longint unsigned model_val(input logic [39:0] d);
        longint unsigned v, p;
        v = 0;
        p = 1;
        for (int i = 0; i < 10; i++) begin
            v += longint'(d[4*i +: 4]) * p;
            p *= 10;
        end
        return v;
    endfunction

    function automatic bit model_err(input logic [39:0] d);
        bit e;
        e = 1'b0;
        for (int i = 0; i < 10; i++)
            if (d[4*i +: 4] > 4'd9) e = 1'b1;
        return e;
    endfunction

    task automatic start(input logic [39:0] d);
        dv = d;
        en = 1'b1;
    endtask

    // called right after start() at a falling edge; returns at the fin cycle
    task automatic wait_done(input string tag, input logic [39:0] d,
                             input bit disturb);
        longint unsigned v, e0, e1;
        bit o, e;
        int cyc;
        v  = model_val(d);
        o  = (v > 64'hFFFF_FFFF);
        e  = model_err(d);
        e0 = v & 64'hFFFF_FFFF;
        e1 = o ? 64'hFFFF_FFFF : e0;
        cyc = 0;
        while (cyc < 30) begin
            @(negedge CLK);
            cyc++;
            en = 1'b0;
            if (disturb && (cyc == 3 || cyc == 7)) begin
                en = 1'b1;
                dv = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
            end
            if (fin0) break;
            if (!busy0 || !busy1) check({tag, ".busy"}, 0, 1);
            if (cyc == 5) begin
                check({tag, ".hold0"}, bin0, prev0);
                check({tag, ".hold1"}, bin1, prev1);
            end
        end
        en = 1'b0;
        check({tag, ".lat"}, cyc, 11);
        check({tag, ".fin1"}, fin1, 1);
        check({tag, ".busyfin"}, {busy0, busy1}, 0);
        check({tag, ".bin0"}, bin0, e0);
        check({tag, ".bin1"}, bin1, e1);
        check({tag, ".ovf"}, {ovf0, ovf1}, {o, o});
        check({tag, ".err"}, {err0, err1}, {e, e});
        prev0 = e0;
        prev1 = e1;
    endtask

    task automatic conv(input string tag, input logic [39:0] d);
        @(negedge CLK);
        start(d);
        wait_done(tag, d, 1'b0);
    endtask

    initial begin
        logic [39:0] d;
        bit seen;
        n_chk  = 0;
        n_fail = 0;
        prev0  = 0;
        prev1  = 0;
        RST = 1'b0;
        en  = 1'b0;
        dv  = '0;
        repeat (3) @(negedge CLK);
        check("rst.bin", {bin0, bin1}, 0);
        check("rst.flags", {busy0, fin0, ovf0, err0, busy1, fin1}, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("idle.busy", {busy0, fin0}, 0);

        conv("t1", dec(50_000_000));
        check("t1.val", bin0, 32'h02FA_F080);
        @(negedge CLK);
        check("t1.finclr", {fin0, fin1, busy0}, 0);
        check("t1.hold", bin0, 32'h02FA_F080);

        conv("t2a", dec(0));
        conv("t2b", dec(64'd4294967295));
        check("t2b.val", bin0, 32'hFFFF_FFFF);
        conv("t3a", dec(64'd4294967296));
        check("t3a.sat", {bin0, bin1}, {32'h0, 32'hFFFF_FFFF});
        conv("t3b", dec(64'd9999999999));
        check("t3b.val", bin0, 32'h540B_E3FF);

        d = 40'h00_0000_001A;
        conv("t4a", d);
        check("t4a.val", {bin0, err0}, {32'd20, 1'b1});
        conv("t4b", dec(7));
        check("t4b.val", {bin0, err0}, {32'd7, 1'b0});

        d = dec(64'd1234567890);
        @(negedge CLK);
        start(d);
        wait_done("t5a", d, 1'b1);
        check("t5a.val", bin0, 32'd1234567890);
        d = dec(64'd987654321);
        start(d);
        wait_done("t5b", d, 1'b0);

        d = dec(64'd3141592653);
        @(negedge CLK);
        start(d);
        repeat (6) begin
            @(negedge CLK);
            en = 1'b0;
        end
        RST = 1'b0;
        @(negedge CLK);
        check("t6.rst", {bin0, busy0, fin0, ovf0, err0, bin1}, 0);
        RST = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (fin0 || fin1 || busy0) seen = 1'b1;
        end
        check("t6.nofin", seen, 0);
        check("t6.out", {bin0, ovf0, err0, bin1}, 0);
        prev0 = 0;
        prev1 = 0;
        conv("t6b", dec(64'd2718281828));

        for (int k = 0; k < 2000; k++) begin
            d = '0;
            for (int i = 0; i < 10; i++)
                d[4*i +: 4] = 4'($urandom_range(0, 9));
            conv("rnd", d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
